// File: rtl/pulse_sequencer.sv
// Programmable burst pulse generator: emits count_r pulses spaced period_r+1 cycles apart.
// Define PULSE_SEQ_CONTINUOUS_EN to make count_r==0 mean "pulse until stop".
module pulse_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulses_left
);

`ifdef PULSE_SEQ_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, n_state;
  logic [WIDTH-1:0] period_r, n_period;
  logic [WIDTH-1:0] count_r, n_count;
  logic [WIDTH-1:0] phase, n_phase;
  logic [WIDTH-1:0] remaining, n_rem;
  logic             n_sig;
  logic [WIDTH-1:0] cnt_eff;
  logic             cont_mode;

  // A cfg write on the start edge must already apply to that burst.
  assign cnt_eff   = cfg_we ? cfg_count : count_r;
  assign cont_mode = CONT && (count_r == '0);

  always_ff @(negedge clk) begin
    if (reset) begin
      state     <= IDLE;
      period_r  <= WIDTH'(4);
      count_r   <= WIDTH'(1);
      phase     <= '0;
      remaining <= '0;
      signal    <= 1'b0;
    end else begin
      state     <= n_state;
      period_r  <= n_period;
      count_r   <= n_count;
      phase     <= n_phase;
      remaining <= n_rem;
      signal    <= n_sig;
    end
  end

  always_comb begin
    n_state  = state;
    n_period = period_r;
    n_count  = count_r;
    n_phase  = phase;
    n_rem    = remaining;
    n_sig    = 1'b0;
    case (state)
      RUN: begin
        if (stop) begin
          n_state = IDLE;
          n_phase = '0;
          n_rem   = '0;
        end else if (phase == period_r) begin
          n_sig   = 1'b1;
          n_phase = '0;
          if (!cont_mode) begin
            n_rem = remaining - WIDTH'(1);
            if (remaining == WIDTH'(1)) n_state = DONE;
          end
        end else begin
          n_phase = phase + WIDTH'(1);
        end
      end
      default: begin
        if (cfg_we) begin
          n_period = cfg_period;
          n_count  = cfg_count;
        end
        if (start && !stop) begin
          n_phase = '0;
          n_rem   = cnt_eff;
          // Empty burst completes immediately unless continuous mode is built in.
          n_state = (cnt_eff == '0 && !CONT) ? DONE : RUN;
        end
      end
    endcase
  end

  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign pulses_left = remaining;

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Control block for the periodic pulse generator path: holds a programmable period and burst length, and emits a burst of single-cycle pulses on `signal` when started. It replaces the fixed divide-by-5 tick with a software-configurable tick source and reports progress with `busy`, `done` and a remaining-pulse count. Sits between the configuration/control logic and any consumer of the periodic tick.

## Interface
- `WIDTH`, default 8: width of period, count and remaining-count fields.

- `clk`  in  1  clock; all state updates on the falling edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the falling edge of `clk`.
- `cfg_we`  in  1  write `cfg_period`/`cfg_count` into the configuration registers.
- `cfg_period`  in  WIDTH  pulse spacing minus one (pulse every `period+1` cycles).
- `cfg_count`  in  WIDTH  pulses per burst.
- `start`  in  1  begin a burst.
- `stop`  in  1  abort a burst.
- `signal`  out  1  registered pulse output, high for exactly one cycle per pulse.
- `busy`  out  1  high while a burst is running.
- `done`  out  1  high after a burst completes normally, until the next `start` or `reset`.
- `pulses_left`  out  WIDTH  pulses still to be emitted in the current burst.

## Operation
- Registers: `period_r` (reset 4), `count_r` (reset 1), `phase` (reset 0), `remaining` (reset 0), state (reset IDLE).
- Output reset values: `signal`=0, `busy`=0, `done`=0, `pulses_left`=0.
- States: IDLE, RUN, DONE. `busy` is 1 only in RUN. `done` is 1 only in DONE.
- `cfg_we` is accepted in IDLE and DONE and ignored in RUN.
- `cfg_we` and `start` on the same edge: the new values are written and used by the burst.
- IDLE/DONE + `start` (no `stop`): go to RUN, `phase`<=0, `remaining`<=count, `done`<=0.
- RUN, each edge:
  - If `phase`==`period_r`: `signal`<=1, `phase`<=0, `remaining`<=`remaining`-1.
  - Otherwise: `signal`<=0, `phase`<=`phase`+1.
- Pulse that takes `remaining` from 1 to 0: same edge goes to DONE (`busy`<=0, `done`<=1).
- `stop` has priority over everything except `reset`:
  - In RUN: next state is IDLE, no pulse on that edge, `done` stays 0, `remaining`<=0.
  - In IDLE/DONE with `start`: `start` is ignored.
- `start` while in RUN is ignored.
- `period_r`=0: `signal` stays high every cycle of the burst.
- `pulses_left` mirrors `remaining`.
- All counters are unsigned WIDTH bits. `phase` never exceeds `period_r`, so it never wraps.
- `reset` mid-burst: all registers return to their reset values on that edge. No pulse is emitted on that edge.

## Timing
- All signals are sampled, and all outputs change, on the falling edge of `clk`. Outputs are registered; there is no combinational input-to-output path.
- If `start` is sampled at edge n, pulse k (k = 1..count) is high in the cycle following edge n+k*(period+1).
- `done` rises and `busy` falls on the same edge as the final pulse.
- `stop` sampled at edge m: `busy`=0 after edge m, and no pulse after edge m.
- A restart from DONE behaves like a start from IDLE. `done` clears on the start edge.

## Configuration
- `PULSE_SEQ_CONTINUOUS_EN` defined: `count_r`=0 selects continuous mode.
  - `start` enters RUN and pulses every `period+1` cycles until `stop` or `reset`.
  - `remaining` and `pulses_left` stay 0; DONE is never reached.
- Not defined: `start` with `count_r`=0 goes directly to DONE on the start edge.
  - Zero pulses are emitted, `busy` stays 0, `done`=1.

## Test plan
- Reset, then `start` with defaults (period 4, count 1) -> one `signal` pulse 5 edges after the start edge. `done` goes 1 and `busy` goes 0 on that same edge.
- `cfg_we` period=2, count=3, then `start` -> pulses at start+3, +6, +9. `pulses_left` steps 3->2->1->0. `done` on edge +9.
- period=2, count=5, `stop` one edge after the first pulse -> `busy`=0 on the next edge, no further pulses, `done`=0, `pulses_left`=0.
- period=0, count=4, with `cfg_we` period=7 asserted mid-burst -> `signal` high for exactly 4 consecutive cycles. `period_r` still reads 0 afterwards.
- count=0, period=1: macro off -> `done`=1 after the start edge, no pulses. Macro on -> pulse every 2 cycles until `stop`.
- `reset` asserted during RUN, after 2 of 5 pulses -> all outputs 0 on that edge, config back to 4/1, and no pulse on the following edges.
